// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, DRAM wait freeze with timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int         MEM_TIMEOUT = 16,
   parameter logic [1:0] LOAD_WSEL   = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_wR,
   input  logic        ex_rf_we,
   input  logic [1:0]  ex_rf_wsel,
   input  logic        ex_redirect,
   input  logic        mem_req,
   input  logic        mem_ack,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        id_ex_stall,
   output logic        ex_mem_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        mem_wb_flush,
   output logic [1:0]  state,
   output logic        mem_err,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      MEM_ERR  = 2'b10,
      UNUSED   = 2'b11
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q;
   logic [7:0] wait_cnt_q;
   logic       mem_err_q;

   logic mem_pending;
   logic freeze;
   logic load_use;

   assign mem_pending = mem_req & ~mem_ack;
   // Every non-error state (including the unreachable encoding) behaves as RUN/MEM_WAIT here.
   assign freeze      = (state_q == MEM_ERR) | mem_pending;
   assign load_use    = ex_rf_we && (ex_rf_wsel == LOAD_WSEL) && (ex_wR != 5'd0) &&
                        ((id_rs1_used && (id_rs1 == ex_wR)) ||
                         (id_rs2_used && (id_rs2 == ex_wR)));

   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (!rst) begin
         if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
         end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         case (state_q)
            MEM_WAIT: begin
               // A completing ack takes priority over the timeout check.
               if (mem_ack || !mem_req) begin
                  state_q    <= RUN;
                  wait_cnt_q <= 8'd0;
               end else if (wait_cnt_q == TIMEOUT_LAST) begin
                  state_q   <= MEM_ERR;
                  mem_err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            MEM_ERR: state_q <= MEM_ERR;
            default: begin
               if (mem_pending) begin
                  state_q    <= MEM_WAIT;
                  wait_cnt_q <= 8'd1;
               end else begin
                  state_q <= RUN;
               end
            end
         endcase
      end
   end

   assign state   = state_q;
   assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if ((if_id_flush || id_ex_flush) && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = 32'h0;
   assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vectors with a queued scoreboard for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_wR = '0;
   logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_rf_we = 1'b0;
   logic [1:0]  ex_rf_wsel = '0;
   logic        ex_redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
   logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic        if_id_flush, id_ex_flush, mem_wb_flush;
   logic [1:0]  state;
   logic        mem_err;
   logic [31:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .LOAD_WSEL(2'b01)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_rf_wsel(ex_rf_wsel),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_wb_flush(mem_wb_flush),
      .state(state), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // Flag order: pc, if_id, id_ex, ex_mem stall; if_id, id_ex, mem_wb flush.
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] LU   = 7'b1100010;
   localparam logic [6:0] BR   = 7'b0000110;
   localparam logic [6:0] FRZ  = 7'b1111001;

   typedef struct packed {
      logic [7:0]  id;
      logic [6:0]  flags;
      logic [1:0]  st;
      logic        err;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;

   function automatic logic [31:0] cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
      return 32'(v);
`else
      return (v < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic check(input string name, input logic [7:0] id,
                        input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s vec=%0d actual=%0h required=%0h", name, id, act, expv);
      end
   endtask

   task automatic drive(input logic r,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] wr, input logic we, input logic [1:0] ws,
                        input logic br, input logic rq, input logic ak,
                        input logic [6:0] ef, input logic [1:0] es, input logic ee,
                        input int sc, input int fc);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      ex_wR = wr; ex_rf_we = we; ex_rf_wsel = ws;
      ex_redirect = br; mem_req = rq; mem_ack = ak;
      e.id = 8'(vec_id); e.flags = ef; e.st = es; e.err = ee;
      e.sc = cnt(sc); e.fc = cnt(fc);
      exp_q.push_back(e);
      vec_id++;
   endtask

   // Monitor: outputs are settled mid-cycle, sample on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("flags", e.id,
                  32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                       if_id_flush, id_ex_flush, mem_wb_flush}), 32'(e.flags));
            check("state", e.id, 32'(state), 32'(e.st));
            check("mem_err", e.id, 32'(mem_err), 32'(e.err));
            check("stall_cnt", e.id, stall_cnt, e.sc);
            check("flush_cnt", e.id, flush_cnt, e.fc);
         end
      end
   end

   initial begin
      //     rst rs1  u rs2  u  wR  we ws    br rq ak  flags st     err sc fc
      drive(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 2'b01, 0, 1, 0, NONE, 2'b00, 0, 0, 0);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, NONE, 2'b00, 0, 0, 0);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b01, 0, 0, 0, LU,   2'b00, 0, 0, 0);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd0, 1, 2'b01, 0, 0, 0, NONE, 2'b00, 0, 1, 1);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b00, 0, 0, 0, NONE, 2'b00, 0, 1, 1);
      drive(0, 5'd7, 1, 5'd0, 0, 5'd7, 1, 2'b01, 0, 0, 0, LU,   2'b00, 0, 1, 1);
      drive(0, 5'd7, 0, 5'd0, 0, 5'd7, 1, 2'b01, 0, 0, 0, NONE, 2'b00, 0, 2, 2);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b01, 1, 0, 0, BR,   2'b00, 0, 2, 2);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 0, 0, BR,   2'b00, 0, 2, 3);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b01, 0, 1, 1, LU,   2'b00, 0, 2, 4);
      // DRAM wait, three freeze cycles then ack on the timeout cycle
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b01, 1, 1, 0, FRZ,  2'b00, 0, 3, 5);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b01, 1, 1, 0, FRZ,  2'b01, 0, 4, 5);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b01, 1, 1, 0, FRZ,  2'b01, 0, 5, 5);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 1, 1, BR,   2'b01, 0, 6, 5);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, NONE, 2'b00, 0, 6, 6);
      // request withdrawn while waiting
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0, FRZ,  2'b00, 0, 6, 6);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, NONE, 2'b01, 0, 7, 6);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, NONE, 2'b00, 0, 7, 6);
      // timeout into the terminal error state
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0, FRZ,  2'b00, 0, 7, 6);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0, FRZ,  2'b01, 0, 8, 6);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0, FRZ,  2'b01, 0, 9, 6);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0, FRZ,  2'b01, 0, 10, 6);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 1, 1, FRZ,  2'b10, 1, 11, 6);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, FRZ,  2'b10, 1, 12, 6);
      // reset pulse recovers
      drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0, NONE, 2'b00, 0, 0, 0);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, NONE, 2'b00, 0, 0, 0);
      drive(0, 5'd0, 0, 5'd5, 1, 5'd5, 1, 2'b01, 0, 0, 0, LU,   2'b00, 0, 0, 0);
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, NONE, 2'b00, 0, 1, 1);
      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
